// File: rtl/div_seq.sv
// Sequential restoring radix-2 divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division, one extra fix-up cycle).
module div_seq #(
  parameter int WIDTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             dbz_o
);

  localparam int CW = $clog2(WIDTH);

  // FIX is only entered in the signed build.
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

`ifdef DIV_SIGNED_EN
  localparam state_e AFTER_CALC = FIX;
`else
  localparam state_e AFTER_CALC = DONE;
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             divisor_zero;

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_rem_q;
  assign dvd_mag = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
  assign dvs_mag = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;
`else
  assign dvd_mag = dividend_i;
  assign dvs_mag = divisor_i;
`endif

  assign divisor_zero = (divisor_i == '0);
  assign in_ready_o   = (state_q == IDLE);
  assign out_valid_o  = (state_q == DONE);

  // The partial remainder stays below the divisor, so a WIDTH+1 bit trial
  // subtraction is enough: its top bit is set exactly when it borrowed.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = divisor_zero ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_d = AFTER_CALC;
      FIX:     state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_o  <= '0;
      remainder_o <= '0;
      dbz_o       <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            if (divisor_zero) begin
              quotient_o  <= '1;
              remainder_o <= dividend_i;
              dbz_o       <= 1'b1;
            end else begin
              cnt_q <= CW'(WIDTH - 1);
              rem_q <= '0;
              quo_q <= dvd_mag;
              dvs_q <= dvs_mag;
`ifdef DIV_SIGNED_EN
              neg_quo_q <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
              neg_rem_q <= dividend_i[WIDTH-1];
`endif
            end
          end
        end
        CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - CW'(1);
`ifndef DIV_SIGNED_EN
          if (cnt_q == '0) begin
            quotient_o  <= quo_nxt;
            remainder_o <= rem_nxt;
            dbz_o       <= 1'b0;
          end
`endif
        end
`ifdef DIV_SIGNED_EN
        FIX: begin
          quotient_o  <= neg_quo_q ? -quo_q : quo_q;
          remainder_o <= neg_rem_q ? -rem_q : rem_q;
          dbz_o       <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random operands
// against an arithmetic reference model; honours DIV_SIGNED_EN when defined.
module tb_div_seq;

  localparam int W = 128;
`ifdef DIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif
  localparam int LIMIT = W + 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  int checks = 0;
  int errors = 0;

  div_seq #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .dbz_o       (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
        q = a;
        r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
`else
      q = a / b;
      r = a % b;
`endif
      z = 1'b0;
    end
  endfunction

  // Issue one operation, measure latency, check result, optionally stall the consumer.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall);
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat;
    model(a, b, eq, er, ez);
    @(negedge clk);
    check({tag, "_ready"}, W'(in_ready), W'(1));
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, W'(lat), (b == '0) ? W'(1) : W'(LAT));
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, W'(dbz), W'(ez));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      dividend = ~a;
      divisor  = 128'h3;
      @(negedge clk);
      check({tag, "_hold_v"}, W'(out_valid), W'(1));
      check({tag, "_hold_rdy"}, W'(in_ready), W'(0));
      check({tag, "_hold_q"}, quotient, eq);
      check({tag, "_hold_r"}, remainder, er);
      check({tag, "_hold_dbz"}, W'(dbz), W'(ez));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drop_v"}, W'(out_valid), W'(0));
    check({tag, "_idle"}, W'(in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] a, b;
    int           sh;

    // Reset state.
    #2;
    check("rst_ready", W'(in_ready), W'(1));
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_q", quotient, '0);
    check("rst_r", remainder, '0);
    check("rst_dbz", W'(dbz), W'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run_op("two_by_one", 128'h2, 128'h1, 0);
    run_op("ones_by_two", '1, 128'h2, 0);
    run_op("small_by_big", 128'h5, 128'h7, 0);
    run_op("near_ones", 128'hffff_ffff_ffff_ffff_ffff_ffff_fffe_ffff,
                        128'hffff_ffff_ffff_ffff_ffff_ffff_ffef_ffff, 0);
    check("near_ones_r_const", remainder, 128'hf_0000);
    run_op("dbz_hold", 128'h1234, '0, 5);
    check("dbz_q_const", quotient, '1);

    // Reset in the middle of a divide aborts it.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 128'hf000_0000_0000_0000_0000_0000_0000_0002;
    divisor  = 128'h00f0_0000_0000_0000_0000_0000_0000_0001;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) check("abort_early_v", W'(out_valid), W'(0));
    end
    check("abort_busy", W'(in_ready), W'(0));
    rst = 1'b1;
    #1;
    check("abort_async_ready", W'(in_ready), W'(1));
    check("abort_async_q", quotient, '0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W + 5; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) begin
        check("abort_quiet_v", W'(out_valid), W'(0));
        check("abort_quiet_rdy", W'(in_ready), W'(1));
      end
    end
    check("abort_r", remainder, '0);
    run_op("post_abort", 128'h2, 128'h1, 0);

`ifdef DIV_SIGNED_EN
    run_op("s_m7_2", -128'sd7, 128'sd2, 0);
    check("s_m7_2_q_const", quotient, -128'sd3);
    run_op("s_7_m2", 128'sd7, -128'sd2, 0);
    check("s_7_m2_r_const", remainder, 128'sd1);
    run_op("s_min_m1", {1'b1, {(W-1){1'b0}}}, '1, 0);
`endif

    // Random operands, with divisors scaled into several magnitude ranges.
    for (int n = 0; n < 24; n++) begin
      a  = {$urandom, $urandom, $urandom, $urandom};
      b  = {$urandom, $urandom, $urandom, $urandom};
      sh = $urandom_range(0, W - 1);
      case ($urandom_range(0, 4))
        0: b = b >> sh;
        1: b = 128'h1;
        2: b = a >> $urandom_range(0, 8);
        3: b = (n % 6 == 0) ? '0 : b;
        default: a = a >> sh;
      endcase
      run_op("rand", a, b, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
